// File: rtl/fpdiv_pkg.sv
// Shared types and select encodings for the fpdiv Goldschmidt datapath controller.
// Optional build macro: FPDIV_CTRL_SETTLE_EN adds a SET cycle ahead of every LD cycle.
package fpdiv_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef FPDIV_CTRL_SETTLE_EN
    S_SEED_B_SET,
    S_SEED_AC_SET,
    S_IT_B_SET,
    S_IT_AC_SET,
`endif
    S_SEED_B_LD,
    S_SEED_AC_LD,
    S_IT_B_LD,
    S_IT_AC_LD,
    S_DONE
  } state_t;

  localparam logic [1:0] MUXA_OPER = 2'b10;
  localparam logic [1:0] MUXA_LOOP = 2'b00;
  localparam logic [1:0] MUXB_SEED = 2'b01;
  localparam logic [1:0] MUXB_OPER = 2'b00;
  localparam logic [1:0] MUXB_LOOP = 2'b10;
  localparam logic [1:0] MUXB_TWOC = 2'b11;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the fpdiv datapath: seed step, then ITERS refinement
// iterations, each step loading B and then A+C, followed by a one-cycle done.
// Optional build macro: FPDIV_CTRL_SETTLE_EN inserts a select-settle cycle per step.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       busy,
  output logic       done,
  output logic [2:0] iter
);

  // First state of each step: the SET cycle when settling, else straight to LD.
`ifdef FPDIV_CTRL_SETTLE_EN
  localparam state_t FIRST_SEED_B  = S_SEED_B_SET;
  localparam state_t FIRST_SEED_AC = S_SEED_AC_SET;
  localparam state_t FIRST_IT_B    = S_IT_B_SET;
  localparam state_t FIRST_IT_AC   = S_IT_AC_SET;
`else
  localparam state_t FIRST_SEED_B  = S_SEED_B_LD;
  localparam state_t FIRST_SEED_AC = S_SEED_AC_LD;
  localparam state_t FIRST_IT_B    = S_IT_B_LD;
  localparam state_t FIRST_IT_AC   = S_IT_AC_LD;
`endif

  state_t     r_state, w_next;
  logic [2:0] r_iter, w_iter_next;
  logic [3:0] w_iter_inc;

  assign w_iter_inc = {1'b0, r_iter} + 4'd1;

  // State and iteration registers; iter clears whenever the FSM lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_iter  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_iter  <= (w_next == S_IDLE) ? 3'd0 : w_iter_next;
    end
  end

  // Next-state walk through the step table; abort preempts any busy state.
  always_comb begin
    w_next      = r_state;
    w_iter_next = r_iter;
    case (r_state)
      S_IDLE:        if (start && !abort) w_next = FIRST_SEED_B;
`ifdef FPDIV_CTRL_SETTLE_EN
      S_SEED_B_SET:  w_next = S_SEED_B_LD;
      S_SEED_AC_SET: w_next = S_SEED_AC_LD;
      S_IT_B_SET:    w_next = S_IT_B_LD;
      S_IT_AC_SET:   w_next = S_IT_AC_LD;
`endif
      S_SEED_B_LD:   w_next = FIRST_SEED_AC;
      S_SEED_AC_LD:  w_next = FIRST_IT_B;
      S_IT_B_LD:     w_next = FIRST_IT_AC;
      S_IT_AC_LD: begin
        w_iter_next = w_iter_inc[2:0];
        w_next      = (w_iter_inc == 4'(ITERS)) ? S_DONE : FIRST_IT_B;
      end
      S_DONE:        w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  // Output decode from registered state only; selects hold across SET and LD.
  always_comb begin
    sel_muxa = MUXA_LOOP;
    sel_muxb = MUXB_OPER;
    enA      = 1'b0;
    enB      = 1'b0;
    enC      = 1'b0;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    case (r_state)
`ifdef FPDIV_CTRL_SETTLE_EN
      S_SEED_B_SET:  begin sel_muxa = MUXA_OPER; sel_muxb = MUXB_SEED; end
      S_SEED_AC_SET: begin sel_muxa = MUXA_OPER; sel_muxb = MUXB_OPER; end
      S_IT_B_SET:    begin sel_muxa = MUXA_LOOP; sel_muxb = MUXB_LOOP; end
      S_IT_AC_SET:   begin sel_muxa = MUXA_LOOP; sel_muxb = MUXB_TWOC; end
`endif
      S_SEED_B_LD:   begin sel_muxa = MUXA_OPER; sel_muxb = MUXB_SEED; enB = 1'b1; end
      S_SEED_AC_LD:  begin sel_muxa = MUXA_OPER; sel_muxb = MUXB_OPER; enA = 1'b1; enC = 1'b1; end
      S_IT_B_LD:     begin sel_muxa = MUXA_LOOP; sel_muxb = MUXB_LOOP; enB = 1'b1; end
      S_IT_AC_LD:    begin sel_muxa = MUXA_LOOP; sel_muxb = MUXB_TWOC; enA = 1'b1; enC = 1'b1; end
      S_DONE:        done = 1'b1;
      default:       ;
    endcase
  end

  assign iter = r_iter;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl: two instances (ITERS=3 and ITERS=1), a
// run-profile reference model, a directed vector table, corner sequences and random traffic.
module tb_fpdiv_ctrl;

`ifdef FPDIV_CTRL_SETTLE_EN
  localparam int SPS = 2;
`else
  localparam int SPS = 1;
`endif

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       ea;
    logic       eb;
    logic       ec;
    logic       busy;
    logic       done;
    logic [2:0] it;
  } out_t;

  typedef struct {
    logic s;
    logic ab;
    logic r;
    out_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic [1:0] rst, st, ab;
  out_t       g [2];

  logic [1:0] a0, b0, a1, b1;
  logic       ea0, eb0, ec0, bz0, dn0, ea1, eb1, ec1, bz1, dn1;
  logic [2:0] it0, it1;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITERS(3)) dut0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .abort(ab[0]),
    .sel_muxa(a0), .sel_muxb(b0), .enA(ea0), .enB(eb0), .enC(ec0),
    .busy(bz0), .done(dn0), .iter(it0));

  fpdiv_ctrl #(.ITERS(1)) dut1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .abort(ab[1]),
    .sel_muxa(a1), .sel_muxb(b1), .enA(ea1), .enB(eb1), .enC(ec1),
    .busy(bz1), .done(dn1), .iter(it1));

  assign g[0] = {a0, b0, ea0, eb0, ec0, bz0, dn0, it0};
  assign g[1] = {a1, b1, ea1, eb1, ec1, bz1, dn1, it1};

  int n_chk = 0, n_fail = 0;
  int pos [2];
  int its [2];
  int done_cnt [2], busy_cnt [2], ld_cnt [2], max_it [2];

  // Whole-run length: S steps of SPS cycles each, plus the done cycle.
  function automatic int run_len(int it);
    return (2 + 2*it)*SPS + 1;
  endfunction

  // Expected outputs for cycle k of a run, from the step table.
  function automatic out_t run_rec(int it, int k);
    out_t o;
    int s;
    bit ld, seed, isb;
    o = '0;
    o.busy = 1'b1;
    if (k == run_len(it) - 1) begin
      o.done = 1'b1;
      o.it   = 3'(it);
      return o;
    end
    s    = k / SPS;
    ld   = (k % SPS) == SPS - 1;
    seed = s < 2;
    isb  = (s % 2) == 0;
    o.a  = seed ? 2'b10 : 2'b00;
    o.b  = seed ? (isb ? 2'b01 : 2'b00) : (isb ? 2'b10 : 2'b11);
    o.eb = ld && isb;
    o.ea = ld && !isb;
    o.ec = ld && !isb;
    o.it = seed ? 3'd0 : 3'((s - 2) / 2);
    return o;
  endfunction

  function automatic out_t model_out(int i);
    return (pos[i] < 0) ? out_t'('0) : run_rec(its[i], pos[i]);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; busy_cnt[i] = 0; ld_cnt[i] = 0; max_it[i] = 0;
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare both DUTs.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) pos[i] = -1;
      else if (pos[i] >= 0) begin
        if (ab[i]) pos[i] = -1;
        else begin
          pos[i]++;
          if (pos[i] == run_len(its[i])) pos[i] = -1;
        end
      end else if (st[i] && !ab[i]) pos[i] = 0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "model_dut0" : "model_dut1", 32'(g[i]), 32'(model_out(i)));
      done_cnt[i] += int'(g[i].done);
      busy_cnt[i] += int'(g[i].busy);
      ld_cnt[i]   += int'(g[i].ea | g[i].eb);
      if (int'(g[i].it) > max_it[i]) max_it[i] = int'(g[i].it);
    end
  endtask

  vec_t tv [6];
  out_t tmp;
  int   tgt;

  initial begin
    its[0] = 3; its[1] = 1;
    pos[0] = -1; pos[1] = -1;
    rst = 2'b11; st = 2'b00; ab = 2'b00;
    clr_cnt();
    step(); step();
    check("reset_state", 32'(g[0]), 32'h0);
    rst = 2'b00;

    // Directed vectors on dut0.
    tmp = '0;
    tv[0] = '{s:1'b0, ab:1'b0, r:1'b1, e:tmp};
    tv[1] = '{s:1'b1, ab:1'b1, r:1'b0, e:tmp};
    tv[2] = '{s:1'b0, ab:1'b1, r:1'b0, e:tmp};
    tmp = '0; tmp.a = 2'b10; tmp.b = 2'b01; tmp.busy = 1'b1; tmp.eb = (SPS == 1);
    tv[3] = '{s:1'b1, ab:1'b0, r:1'b0, e:tmp};
    tmp = '0; tmp.a = 2'b10; tmp.busy = 1'b1;
    if (SPS == 2) begin tmp.b = 2'b01; tmp.eb = 1'b1; end
    else begin tmp.b = 2'b00; tmp.ea = 1'b1; tmp.ec = 1'b1; end
    tv[4] = '{s:1'b1, ab:1'b0, r:1'b0, e:tmp};
    tv[5] = '{s:1'b0, ab:1'b0, r:1'b1, e:out_t'('0)};
    for (int k = 0; k < 6; k++) begin
      st[0] = tv[k].s; ab[0] = tv[k].ab; rst[0] = tv[k].r;
      step();
      check($sformatf("vec%0d", k), 32'(g[0]), 32'(tv[k].e));
    end
    st[0] = 0; ab[0] = 0; rst[0] = 0;
    step();

    // Start held for a whole run: one done, then one idle cycle before the next run.
    clr_cnt();
    st[0] = 1;
    for (int k = 0; k < run_len(3); k++) step();
    check("held_done_cnt", done_cnt[0], 1);
    check("held_busy_cnt", busy_cnt[0], (SPS == 2) ? 2*8 + 1 : 8 + 1);
    check("held_ld_cnt", ld_cnt[0], 8);
    step();
    check("held_idle_gap", 32'(g[0].busy), 0);
    step();
    check("held_restart", 32'(g[0].busy), 1);
    st[0] = 0; ab[0] = 1; step(); ab[0] = 0;
    check("abort_stop", 32'(g[0].busy), 0);

    // Reset while in the first IT_B LD.
    st[0] = 1; step(); st[0] = 0;
    tgt = 2*SPS + SPS - 1;
    for (int k = 0; k < tgt; k++) step();
    check("at_itb_ld", 32'(g[0].eb), 1);
    rst[0] = 1; step(); rst[0] = 0;
    check("reset_mid_run", 32'(g[0]), 32'h0);
    step(); step();
    clr_cnt();
    st[0] = 1; step(); st[0] = 0;
    for (int k = 1; k < run_len(3); k++) step();
    check("post_reset_done", done_cnt[0], 1);
    check("post_reset_iter", max_it[0], 3);
    step();
    check("post_reset_idle", 32'(g[0].busy), 0);

    // Abort during IT_AC LD at iter 1.
    clr_cnt();
    st[0] = 1; step(); st[0] = 0;
    tgt = 5*SPS + SPS - 1;
    for (int k = 0; k < tgt; k++) step();
    check("at_itac_ld_iter", 32'(g[0].it), 1);
    check("at_itac_ld_en", 32'({g[0].ea, g[0].ec}), 3);
    ab[0] = 1; step(); ab[0] = 0;
    check("abort_out", 32'(g[0]), 32'h0);
    for (int k = 0; k < 20; k++) step();
    check("abort_no_done", done_cnt[0], 0);

    // ITERS=1 instance.
    clr_cnt();
    st[1] = 1; step(); st[1] = 0;
    for (int k = 1; k < run_len(1); k++) step();
    check("it1_ld_cnt", ld_cnt[1], 4);
    check("it1_done_cnt", done_cnt[1], 1);
    check("it1_busy_cnt", busy_cnt[1], (SPS == 2) ? 9 : 5);
    check("it1_max_iter", max_it[1], 1);
    check("it1_last_done", 32'(g[1].done), 1);
    step();
    check("it1_idle", 32'(g[1].busy), 0);

    // Random traffic on both instances against the model.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  = ($urandom_range(0, 3) == 0);
        ab[i]  = ($urandom_range(0, 24) == 0);
        rst[i] = ($urandom_range(0, 79) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
